// File: rtl/sv39_ptw_pkg.sv
// Shared types and constants for the Sv39 page-table walker and its CBus port.
package sv39_ptw_pkg;

  localparam int LEVELS = 3;
  localparam int PAGE_SHIFT = 12;
  localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

  localparam logic [2:0] MSIZE8 = 3'd3;
  localparam logic [7:0] MLEN1 = 8'd0;
  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } ptw_acc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ptw_state_t;

  typedef struct packed {
    logic [3:0]  mode;
    logic [15:0] asid;
    logic [43:0] ppn;
  } satp_t;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] rdata;
  } cbus_resp_t;

  // Byte address of the 8-byte PTE selected by vpn inside the table at base.
  function automatic logic [63:0] pte_addr(input logic [43:0] base, input logic [8:0] vpn);
    return {8'd0, base, 12'd0} + {52'd0, vpn, 3'd0};
  endfunction

endpackage

// File: rtl/sv39_ptw_pte_check.sv
// Combinational decode of one PTE: validity, leaf/pointer, alignment, permissions.
// PTW_AD_CHECK_EN adds accessed/dirty-bit faults on leaves.
module pte_check
  import sv39_ptw_pkg::*;
(
  input  pte_t        pte,
  input  logic [1:0]  level,
  input  ptw_acc_t    acc,
  input  logic [1:0]  mode,
  input  logic [63:0] vaddr,
  output logic        fault,
  output logic        descend,
  output logic [63:0] paddr
);

  logic        invalid_s;
  logic        leaf_s;
  logic        misalign_s;
  logic        perm_s;
  logic        ad_s;
  logic [43:0] ppn_s;
  logic        unused_s;

  assign unused_s = ^{vaddr[63:30], pte.rsw, pte.g, pte.a, pte.d};

  // Classify the PTE and build the final physical address.
  always_comb begin
    invalid_s  = !pte.v || (!pte.r && pte.w) || (pte.reserved != 10'd0);
    leaf_s     = pte.r || pte.x;
    misalign_s = 1'b0;
    ppn_s      = pte.ppn;
    // Superpages take the untranslated VPN bits below their level.
    case (level)
      2'd2: begin
        misalign_s = (pte.ppn[17:0] != 18'd0);
        ppn_s      = {pte.ppn[43:18], vaddr[29:12]};
      end
      2'd1: begin
        misalign_s = (pte.ppn[8:0] != 9'd0);
        ppn_s      = {pte.ppn[43:9], vaddr[20:12]};
      end
      default: begin
        misalign_s = 1'b0;
        ppn_s      = pte.ppn;
      end
    endcase
    case (acc)
      ACC_FETCH: perm_s = !pte.x;
      ACC_LOAD:  perm_s = !pte.r;
      ACC_STORE: perm_s = !(pte.r && pte.w);
      default:   perm_s = 1'b1;
    endcase
    if (mode == 2'd0) begin
      perm_s = perm_s || !pte.u;
    end else if (mode == 2'd1) begin
      perm_s = perm_s || pte.u;
    end else begin
      perm_s = perm_s;
    end
`ifdef PTW_AD_CHECK_EN
    ad_s = !pte.a || ((acc == ACC_STORE) && !pte.d);
`else
    ad_s = 1'b0;
`endif
    descend = !invalid_s && !leaf_s && (level != 2'd0);
    fault   = invalid_s || (!leaf_s && (level == 2'd0)) ||
              (leaf_s && (misalign_s || perm_s || ad_s));
    paddr   = {8'd0, ppn_s, vaddr[11:0]};
  end

endmodule

// File: rtl/sv39_ptw.sv
// Sv39 hardware page-table walker: one translation at a time, PTE reads over CBus.
// Optional PTW_AD_CHECK_EN enables A/D-bit faults in pte_check.
module sv39_ptw
  import sv39_ptw_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  satp_t       satp,
  input  logic [1:0]  mode,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_vaddr,
  input  logic [1:0]  req_acc,
  output logic        resp_valid,
  output logic [63:0] resp_paddr,
  output logic        resp_fault,
  output cbus_req_t   creq,
  input  cbus_resp_t  cresp
);

  ptw_state_t  state_r, state_s;
  logic [1:0]  level_r;
  logic [63:0] vaddr_r;
  ptw_acc_t    acc_r;
  logic [1:0]  mode_r;
  logic [43:0] base_ppn_r;
  logic        bypass_r;
  logic        flush_pend_r;
  logic [63:0] paddr_r;
  logic        fault_r;

  logic        accept_s, beat_s, descend_s, finish_s;
  logic        chk_fault_s, chk_descend_s;
  logic [63:0] chk_paddr_s;
  logic [8:0]  vpn_s;
  pte_t        pte_s;
  logic        unused_s;

  assign pte_s    = pte_t'(cresp.rdata);
  assign beat_s   = cresp.ready && cresp.last;
  assign accept_s = req_valid && (state_r == ST_IDLE) && !flush;
  assign unused_s = ^{satp.asid, vaddr_r[63:39]};

  pte_check u_pte_check (
    .pte     (pte_s),
    .level   (level_r),
    .acc     (acc_r),
    .mode    (mode_r),
    .vaddr   (vaddr_r),
    .fault   (chk_fault_s),
    .descend (chk_descend_s),
    .paddr   (chk_paddr_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic; a flush seen in WAIT still waits out the open beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_ISSUE;
        else          state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (flush)         state_s = ST_IDLE;
        else if (bypass_r) state_s = ST_DONE;
        else if (beat_s)   state_s = chk_descend_s ? ST_ISSUE : ST_DONE;
        else               state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (!beat_s)                    state_s = ST_WAIT;
        else if (flush_pend_r || flush) state_s = ST_IDLE;
        else if (chk_descend_s)         state_s = ST_ISSUE;
        else                            state_s = ST_DONE;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign descend_s = (state_s == ST_ISSUE) && (state_r != ST_IDLE);
  assign finish_s  = (state_s == ST_DONE) && (state_r != ST_DONE);

  // Request capture, per-level base tracking and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      vaddr_r      <= 64'd0;
      acc_r        <= ACC_FETCH;
      mode_r       <= 2'd0;
      base_ppn_r   <= 44'd0;
      level_r      <= 2'd2;
      bypass_r     <= 1'b0;
      flush_pend_r <= 1'b0;
      paddr_r      <= 64'd0;
      fault_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        vaddr_r      <= req_vaddr;
        acc_r        <= ptw_acc_t'(req_acc);
        mode_r       <= mode;
        base_ppn_r   <= satp.ppn;
        level_r      <= 2'd2;
        bypass_r     <= (mode == 2'd3) || (satp.mode != SATP_MODE_SV39);
        flush_pend_r <= 1'b0;
      end else if ((state_r == ST_WAIT) && flush) begin
        flush_pend_r <= 1'b1;
      end
      if (descend_s) begin
        base_ppn_r <= pte_s.ppn;
        level_r    <= level_r - 2'd1;
      end
      if (finish_s) begin
        paddr_r <= bypass_r ? vaddr_r : (chk_fault_s ? 64'd0 : chk_paddr_s);
        fault_r <= !bypass_r && chk_fault_s;
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    case (level_r)
      2'd2:    vpn_s = vaddr_r[38:30];
      2'd1:    vpn_s = vaddr_r[29:21];
      default: vpn_s = vaddr_r[20:12];
    endcase
    req_ready   = (state_r == ST_IDLE);
    resp_valid  = (state_r == ST_DONE);
    resp_paddr  = paddr_r;
    resp_fault  = fault_r;
    creq        = '0;
    creq.valid  = ((state_r == ST_ISSUE) && !bypass_r) || (state_r == ST_WAIT);
    creq.addr   = pte_addr(base_ppn_r, vpn_s);
    creq.size   = MSIZE8;
    creq.len    = MLEN1;
    creq.burst  = AXI_BURST_FIXED;
  end

endmodule

// File: tb/tb_sv39_ptw.sv
// Self-checking bench for sv39_ptw: memory-backed CBus responder plus response scoreboard.
module tb_sv39_ptw;
  import sv39_ptw_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, resp_valid, resp_fault;
  satp_t       satp;
  logic [1:0]  mode, req_acc;
  logic [63:0] req_vaddr, resp_paddr;
  cbus_req_t   creq;
  cbus_resp_t  cresp;

  always #5 clk = ~clk;

  sv39_ptw dut (
    .clk(clk), .reset(reset), .satp(satp), .mode(mode), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_acc(req_acc),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_fault(resp_fault),
    .creq(creq), .cresp(cresp)
  );

  typedef struct {
    logic [63:0] paddr;
    logic        fault;
    int          lat;
  } exp_t;

  localparam logic [43:0] ROOT = 44'h80000;
  localparam logic [43:0] L1T  = 44'h80001;
  localparam logic [43:0] L0T  = 44'h80002;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] addr_q[$];
  logic [63:0] arb_exp;
  logic [63:0] mem [logic [63:0]];
  int checks = 0, fails = 0, cyc = 0, acc_cyc = 0;
  int arb_lat = 1, arb_cnt = 0, beats = 0, resp_cnt = 0;
  bit creq_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // CBus responder: completes a read after arb_lat extra valid cycles and checks its address.
  always @(negedge clk) begin
    cresp.ready = 1'b0;
    cresp.last  = 1'b0;
    if (creq.valid === 1'b1) begin
      creq_seen = 1'b1;
      if (arb_cnt >= arb_lat) begin
        cresp.ready = 1'b1;
        cresp.last  = 1'b1;
        cresp.rdata = mem.exists(creq.addr) ? mem[creq.addr] : 64'd0;
        arb_cnt = 0;
        beats++;
        checks++;
        if (addr_q.size() == 0) begin
          fails++;
          $display("FAIL cbus_read: unexpected read at %h, required none", creq.addr);
        end else begin
          arb_exp = addr_q.pop_front();
          if (creq.addr !== arb_exp || creq.is_write !== 1'b0 || creq.size !== MSIZE8 ||
              creq.len !== MLEN1 || creq.burst !== AXI_BURST_FIXED) begin
            fails++;
            $display("FAIL cbus_read: addr=%h wr=%b size=%0d len=%0d burst=%0d, required addr=%h rd size=%0d len=%0d burst=%0d",
                     creq.addr, creq.is_write, creq.size, creq.len, creq.burst,
                     arb_exp, MSIZE8, MLEN1, AXI_BURST_FIXED);
          end
        end
      end else begin
        arb_cnt++;
      end
    end else begin
      arb_cnt = 0;
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid pulse.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      resp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: paddr=%h fault=%b, required no response", resp_paddr, resp_fault);
      end else begin
        mon_e = exp_q.pop_front();
        if (resp_paddr !== mon_e.paddr || resp_fault !== mon_e.fault ||
            (mon_e.lat >= 0 && (cyc - acc_cyc) != mon_e.lat)) begin
          fails++;
          $display("FAIL resp: paddr=%h fault=%b lat=%0d, required paddr=%h fault=%b lat=%0d",
                   resp_paddr, resp_fault, cyc - acc_cyc, mon_e.paddr, mon_e.fault, mon_e.lat);
        end
      end
    end
  end

  function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] fl);
    return {10'd0, ppn, 2'd0, fl};
  endfunction

  function automatic logic [63:0] tbl_addr(input logic [43:0] t, input logic [63:0] va, input int lvl);
    return (64'(t) << 12) + (((va >> (12 + 9 * lvl)) & 64'h1FF) * 64'd8);
  endfunction

  function automatic logic [63:0] leaf_pa(input logic [43:0] ppn, input logic [63:0] va, input int lvl);
    logic [63:0] mask;
    mask = (64'd1 << (9 * lvl)) - 64'd1;
    return (((64'(ppn) & ~mask) | ((va >> 12) & mask)) << 12) | (va & 64'hFFF);
  endfunction

  task automatic send(input logic [63:0] va, input logic [1:0] acc, input logic [1:0] md);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      fails++;
      $display("FAIL req_ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_vaddr = va;
    req_acc   = acc;
    mode      = md;
    req_valid = 1'b1;
    acc_cyc   = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      fails++;
      $display("FAIL outstanding: %0d responses and %0d reads pending, required 0",
               exp_q.size(), addr_q.size());
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic walk(input logic [63:0] va, input logic [1:0] acc, input logic [1:0] md,
                      input int leaf_lvl, input logic [43:0] leaf_ppn, input logic [7:0] flags,
                      input logic exp_fault, input int lat);
    logic [43:0] tbl [3];
    logic [63:0] a;
    exp_t        e;
    tbl[2] = ROOT;
    tbl[1] = L1T;
    tbl[0] = L0T;
    mem.delete();
    arb_lat = lat;
    for (int l = 2; l >= leaf_lvl; l--) begin
      a = tbl_addr(tbl[l], va, l);
      addr_q.push_back(a);
      if (l == leaf_lvl) mem[a] = mk_pte(leaf_ppn, flags);
      else               mem[a] = mk_pte(tbl[l - 1], 8'h01);
    end
    e.paddr = exp_fault ? 64'd0 : leaf_pa(leaf_ppn, va, leaf_lvl);
    e.fault = exp_fault;
    e.lat   = (3 - leaf_lvl) * (lat + 1) + 1;
    exp_q.push_back(e);
    send(va, acc, md);
    wait_done(200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks += 5;
    if (req_ready !== 1'b1)     begin fails++; $display("FAIL reset_ready: %b, required 1", req_ready); end
    if (resp_valid !== 1'b0)    begin fails++; $display("FAIL reset_resp_valid: %b, required 0", resp_valid); end
    if (resp_paddr !== 64'd0)   begin fails++; $display("FAIL reset_paddr: %h, required 0", resp_paddr); end
    if (resp_fault !== 1'b0)    begin fails++; $display("FAIL reset_fault: %b, required 0", resp_fault); end
    if (creq.valid !== 1'b0)    begin fails++; $display("FAIL reset_creq: %b, required 0", creq.valid); end
  endtask

  task automatic test_bypass();
    exp_t e;
    creq_seen = 1'b0;
    e = '{paddr: 64'h8000_1234, fault: 1'b0, lat: 2};
    exp_q.push_back(e);
    send(64'h8000_1234, 2'd1, 2'd3);
    wait_done(20);
    satp.mode = 4'd0;
    e = '{paddr: 64'h0000_0040_0000_0abc, fault: 1'b0, lat: 2};
    exp_q.push_back(e);
    send(64'h0000_0040_0000_0abc, 2'd2, 2'd1);
    wait_done(20);
    satp.mode = SATP_MODE_SV39;
    checks++;
    if (creq_seen !== 1'b0) begin fails++; $display("FAIL bypass_creq: creq.valid seen=%b, required 0", creq_seen); end
  endtask

  task automatic test_walk_4k();
    walk(64'h4000_0123, 2'd1, 2'd1, 0, 44'h80123, 8'hCF, 1'b0, 1);
    walk(64'h0000_0012_3456_7abc, 2'd0, 2'd1, 0, 44'h9a5a5, 8'hCF, 1'b0, 2);
  endtask

  task automatic test_superpage();
    walk(64'h4000_0123, 2'd1, 2'd1, 2, 44'h40001, 8'hCF, 1'b1, 1);
    walk(64'h4123_4567, 2'd1, 2'd1, 2, 44'h80000, 8'hCF, 1'b0, 1);
    walk(64'h4020_5678, 2'd2, 2'd1, 1, 44'h80200, 8'hCF, 1'b0, 2);
    walk(64'h4020_5678, 2'd1, 2'd1, 1, 44'h80201, 8'hCF, 1'b1, 2);
  endtask

  task automatic test_perm();
    walk(64'h4000_1000, 2'd2, 2'd1, 0, 44'h80300, 8'hCB, 1'b1, 1);
    walk(64'h4000_1000, 2'd1, 2'd0, 0, 44'h80300, 8'hCF, 1'b1, 1);
    walk(64'h4000_1000, 2'd1, 2'd0, 0, 44'h80300, 8'hDF, 1'b0, 1);
    walk(64'h4000_1000, 2'd1, 2'd1, 0, 44'h80300, 8'hDF, 1'b1, 1);
    walk(64'h4000_1000, 2'd0, 2'd1, 0, 44'h80300, 8'hC7, 1'b1, 1);
    walk(64'h4000_1000, 2'd2, 2'd1, 0, 44'h80300, 8'hC7, 1'b0, 1);
    walk(64'h4000_1000, 2'd1, 2'd1, 2, 44'h80300, 8'h00, 1'b1, 1);
    walk(64'h4000_1000, 2'd1, 2'd1, 1, 44'h80300, 8'h05, 1'b1, 1);
    walk(64'h4000_1000, 2'd1, 2'd1, 0, 44'h80300, 8'h01, 1'b1, 1);
  endtask

  task automatic test_ad();
`ifdef PTW_AD_CHECK_EN
    walk(64'h4000_2000, 2'd2, 2'd1, 0, 44'h80400, 8'h47, 1'b1, 1);
    walk(64'h4000_2000, 2'd1, 2'd1, 0, 44'h80400, 8'h0B, 1'b1, 1);
`else
    walk(64'h4000_2000, 2'd2, 2'd1, 0, 44'h80400, 8'h47, 1'b0, 1);
    walk(64'h4000_2000, 2'd1, 2'd1, 0, 44'h80400, 8'h0B, 1'b0, 1);
`endif
  endtask

  task automatic test_flush_wait();
    int n = 0;
    int r0, b0;
    mem.delete();
    arb_lat = 4;
    mem[tbl_addr(ROOT, 64'h4000_0123, 2)] = mk_pte(L1T, 8'h01);
    addr_q.push_back(tbl_addr(ROOT, 64'h4000_0123, 2));
    r0 = resp_cnt;
    b0 = beats;
    send(64'h4000_0123, 2'd1, 2'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    while (beats == b0 && n < 20) begin
      checks++;
      if (creq.valid !== 1'b1) begin fails++; $display("FAIL flush_hold: creq.valid=%b, required 1", creq.valid); end
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (beats == b0 || creq.valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_beat: beats=%0d creq.valid=%b, required beats=%0d valid=1", beats, creq.valid, b0 + 1);
    end
    @(negedge clk);
    #1;
    checks += 2;
    if (req_ready !== 1'b1)  begin fails++; $display("FAIL flush_ready: %b, required 1", req_ready); end
    if (creq.valid !== 1'b0) begin fails++; $display("FAIL flush_drop: creq.valid=%b, required 0", creq.valid); end
    repeat (5) @(negedge clk);
    checks++;
    if (resp_cnt != r0) begin fails++; $display("FAIL flush_noresp: %0d responses, required 0", resp_cnt - r0); end
    wait_done(5);
  endtask

  task automatic test_flush_issue();
    int r0, b0;
    mem.delete();
    arb_lat = 3;
    r0 = resp_cnt;
    b0 = beats;
    send(64'h4000_0123, 2'd1, 2'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks += 2;
    if (creq.valid !== 1'b0) begin fails++; $display("FAIL flush_issue_creq: %b, required 0", creq.valid); end
    if (req_ready !== 1'b1)  begin fails++; $display("FAIL flush_issue_ready: %b, required 1", req_ready); end
    repeat (5) @(negedge clk);
    checks++;
    if (resp_cnt != r0 || beats != b0) begin
      fails++;
      $display("FAIL flush_issue_quiet: resp=%0d beats=%0d, required 0 and 0", resp_cnt - r0, beats - b0);
    end
  endtask

  task automatic test_flush_accept();
    int r0;
    r0 = resp_cnt;
    creq_seen = 1'b0;
    @(negedge clk);
    req_vaddr = 64'h4000_0123;
    req_acc   = 2'd1;
    mode      = 2'd1;
    req_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (creq_seen !== 1'b0 || resp_cnt != r0) begin
      fails++;
      $display("FAIL flush_accept: creq_seen=%b resp=%0d, required 0 and 0", creq_seen, resp_cnt - r0);
    end
  endtask

  task automatic test_reset_midwalk();
    int r0;
    mem.delete();
    arb_lat = 5;
    r0 = resp_cnt;
    send(64'h4000_0123, 2'd1, 2'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 2;
    if (creq.valid !== 1'b0) begin fails++; $display("FAIL midwalk_reset_creq: %b, required 0", creq.valid); end
    if (req_ready !== 1'b1)  begin fails++; $display("FAIL midwalk_reset_ready: %b, required 1", req_ready); end
    repeat (8) @(negedge clk);
    checks++;
    if (resp_cnt != r0) begin fails++; $display("FAIL midwalk_reset_noresp: %0d responses, required 0", resp_cnt - r0); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] va;
    for (int i = 0; i < 4; i++) begin
      va = 64'h4000_0000 | (64'(i) << 21) | (64'(i + 3) << 12) | 64'(16 * i + 8);
      walk(va, (i % 2 == 0) ? 2'd1 : 2'd0, 2'd1, 0, 44'h80100 + 44'(i), 8'hCF, 1'b0, i);
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_vaddr = 64'd0;
    req_acc   = 2'd0;
    mode      = 2'd1;
    cresp     = '0;
    satp      = '{mode: SATP_MODE_SV39, asid: 16'd0, ppn: ROOT};
    test_reset();
    test_bypass();
    test_walk_4k();
    test_superpage();
    test_perm();
    test_ad();
    test_flush_wait();
    test_flush_issue();
    test_flush_accept();
    test_reset_midwalk();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/sv39_ptw.md
SV39_PTW -- requirements
Module: sv39_ptw

Interface
REQ-001 LEVELS, 3, number of Sv39 page-table levels walked (fixed at 3; not overridable).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 satp  input  satp_t  current satp; mode field 8 = Sv39, root PPN in ppn field.
REQ-005 mode  input  2  current privilege (0=U, 1=S, 3=M).
REQ-006 flush  input  1  sfence/satp-write pulse; aborts any walk in progress.
REQ-007 req_valid  input  1  translation request.
REQ-008 req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready.
REQ-009 req_vaddr  input  64  virtual address.
REQ-010 req_acc  input  2  access type: 0=fetch, 1=load, 2=store.
REQ-011 resp_valid  output  1  one-cycle pulse carrying the result.
REQ-012 resp_paddr  output  64  translated physical address; 0 when resp_fault is set.
REQ-013 resp_fault  output  1  page fault for the accepted request.
REQ-014 creq  output  cbus_req_t  PTE read request toward CBusArbiter.
REQ-015 cresp  input  cbus_resp_t  arbiter response; a beat completes on ready & last.

Function
REQ-016 States: IDLE, ISSUE, WAIT, DONE; level counter runs 2 down to 0.
REQ-017 Bypass: mode==3 or satp.mode!=8 -> DONE on the next cycle with paddr=vaddr, fault=0, and no CBus traffic.
REQ-018 On acceptance, the request latches vaddr/acc/mode/satp.ppn, sets level=2, and enters ISSUE.
REQ-019 PTE address = (base_ppn<<12) + vaddr[12+9*level +: 9]*8; base_ppn is satp.ppn at level 2, otherwise the previous PTE's ppn.
REQ-020 ISSUE/WAIT drive creq.valid=1, is_write=0, size=MSIZE8, len=MLEN1, burst=AXI_BURST_FIXED; the request is held stable until ready & last.
REQ-021 Fault if V=0, or (R=0 & W=1), or bits[63:54]!=0 -> DONE with fault.
REQ-022 Non-leaf (R=0 & X=0): at level>0, decrement level and go to ISSUE; at level 0, fault.
REQ-023 Leaf: fault if superpage misaligned (level 2: ppn[17:0]!=0; level 1: ppn[8:0]!=0).
REQ-024 Leaf permission: fetch needs X; load needs R; store needs R&W; U-mode needs U=1; S-mode fault if U=1 (no SUM/MXR).
REQ-025 paddr = {8'b0, ppn with the low 9*level bits replaced by the matching vaddr VPN bits, vaddr[11:0]}.
REQ-026 DONE drives resp_valid=1 for exactly one cycle, then returns to IDLE; req_ready stays low in DONE.
REQ-027 Best case is 2 cycles from acceptance for bypass; a 3-level walk is 3x(arbiter latency + 1) + 1 cycles.
REQ-028 flush in IDLE or DONE: no effect. In ISSUE: drop creq next cycle and go to IDLE with no response. In WAIT: hold creq until ready & last, discard the data, go to IDLE with no response.
REQ-029 A flush coinciding with req_valid in IDLE blocks acceptance that cycle.

Reset
REQ-030 reset forces IDLE, level=2, creq.valid=0, resp_valid=0, resp_fault=0, resp_paddr=0, and req_ready=1 on the following cycle.
REQ-031 reset mid-walk abandons the CBus transaction immediately; the arbiter tolerates the dropped valid because it is reset concurrently.

Configuration
REQ-032 Macro PTW_AD_CHECK_EN defined: a leaf with A=0, or a store to a leaf with D=0, faults.
REQ-033 PTW_AD_CHECK_EN undefined: A and D bits are ignored; there is no hardware A/D update in either case.

Structure
REQ-034 pte_t (packed Sv39 PTE), ptw_acc_t, ptw_state_t, PAGE_SHIFT=12, and SATP_MODE_SV39=8 belong in common.
REQ-035 Sub-module pte_check holds the combinational leaf/valid/permission/misalign decode.

Verification
REQ-036 mode=3, vaddr 0x8000_1234 -> resp 2 cycles after acceptance, paddr 0x8000_1234, no creq.valid.
REQ-037 satp.ppn=0x80000, 3-level 4 KiB map of VA 0x4000_0123 to PPN 0x80123 with RWXV, load -> 3 CBus reads at 0x8000_0008, then at the L1 table and L0 table addresses, paddr 0x8012_3123.
REQ-038 L2 leaf PTE with ppn 0x40001 (misaligned 1 GiB page) -> fault=1, paddr=0.
REQ-039 Store to a leaf with W=0 -> fault; U-mode access to a leaf with U=0 -> fault.
REQ-040 flush asserted while in WAIT -> creq held until ready & last, no resp_valid, and req_ready=1 the cycle after return.
REQ-041 Under PTW_AD_CHECK_EN, a store to a leaf with A=1 and D=0 -> fault; with the macro undefined, the same store -> success.
